edf_irq_sched: RTL and testbench
================================

EDF_IRQ_SCHED -- requirements
Module: edf_irq_sched

Interface
REQ-001 SHALL have parameter NrIrqs, default 32: number of interrupt sources, a power of two and at least 2.
REQ-002 SHALL have parameter PrioWidth, default 8: deadline width; a lower value means more urgent.
REQ-003 SHALL have parameter NestDepth, default 4: maximum number of nested active interrupts.
REQ-004 SHALL have the following ports; IdxW = $clog2(NrIrqs), ThrW = PrioWidth+1:
 clk_i  in  1  clock; all state updates on the rising edge
 rst_i  in  1  asynchronous, active-high reset
 irq_src_i  in  NrIrqs  level interrupt sources, already synchronous to clk_i
 cfg_we_i  in  1  configuration write strobe
 cfg_idx_i  in  IdxW  index of the source being configured
 cfg_ie_i  in  1  enable value to write
 cfg_prio_i  in  PrioWidth  deadline value to write
 irq_valid_o  out  1  request to the core
 irq_id_o  out  IdxW  ID of the offered source
 irq_prio_o  out  PrioWidth  deadline of the offered source
 irq_ack_i  in  1  core claims the offered interrupt
 irq_done_i  in  1  core completes the innermost active interrupt
 thr_o  out  ThrW  current preemption threshold
 depth_o  out  $clog2(NestDepth+1)  current nesting depth

Function
REQ-005 SHALL register irq_src_i each cycle; a rising edge (src & ~src_q) while ie[i]=1 SHALL set pending[i].
REQ-006 Edges on disabled sources SHALL be discarded.
REQ-007 A cfg_we_i write SHALL update ie[idx] and prio[idx] on the next edge.
REQ-008 A write with cfg_ie_i=0 SHALL also clear pending[idx].
REQ-009 SHALL select the winner with one combinational irq_arbiter instance:
 - valid = pending & ie; prio = prio registers
 - lowest prio value wins; ties go to the lowest index
REQ-010 The FSM SHALL have exactly two states, IDLE and REQ.
REQ-011 IDLE->REQ SHALL occur when all of the following hold: arbiter valid, {1'b0,winner_prio} < thr (strict), and depth < NestDepth.
 - On that transition, winner ID and prio SHALL be latched into irq_id_o and irq_prio_o.
 - Latency from a pending bit setting to irq_valid_o=1 SHALL be one cycle.
REQ-012 irq_valid_o SHALL be 1 exactly in REQ.
REQ-013 irq_id_o and irq_prio_o SHALL hold stable in REQ until ack, regardless of new edges or configuration writes.
REQ-014 On REQ with irq_ack_i=1:
 - clear pending[irq_id_o]
 - push thr onto the stack
 - thr <= {1'b0,irq_prio_o}
 - depth increments
 - return to IDLE
REQ-015 irq_ack_i SHALL be ignored in IDLE.
REQ-016 irq_done_i with depth>0 SHALL pop the stack into thr and decrement depth; irq_done_i with depth=0 SHALL be ignored.
REQ-017 A simultaneous ack and done SHALL act as pop-then-push: thr <= claimed prio, depth unchanged, and the stack entry below is preserved.
REQ-018 If a rising edge on source i coincides with the ack-clear of i, set SHALL win and pending[i]=1.
REQ-019 At depth=NestDepth, no new request SHALL be issued; pending bits SHALL keep accumulating.
REQ-020 thr SHALL reset to 2**PrioWidth, so a deadline of all-ones is still serviceable at depth 0.
REQ-021 The FSM SHALL return to IDLE after each ack, so re-arbitration of later arrivals occurs on the next cycle.

Reset
REQ-022 While rst_i=1, the following SHALL hold:
 - state=IDLE, irq_valid_o=0, irq_id_o=0, irq_prio_o=0
 - thr_o=2**PrioWidth, depth_o=0, stack contents=0
 - pending=0, ie=0, prio=all-ones, src_q=0
REQ-023 Reset asserted mid-request SHALL drop irq_valid_o immediately (asynchronously) and discard all nesting state.

Structure
REQ-024 A shared package edf_pkg SHALL hold the default NrIrqs, PrioWidth, NestDepth and the FSM state enum.
REQ-025 The only sub-module SHALL be irq_arbiter.
REQ-026 The nesting stack SHALL be a register array indexed by depth; no FIFO IP SHALL be used.

Verification
REQ-027 SHALL cover these directed scenarios:
 - Reset, then enable IRQ 5 with prio 20 and pulse src[5] -> irq_valid_o=1 one cycle after pending sets, id=5, prio=20; ack -> thr_o=20, depth_o=1.
 - With IRQs 3 and 9 both at prio 7 and pending together -> id=3 offered first; after done, id=9 offered.
 - Active prio 20, IRQ 2 prio 20 pends -> no request; IRQ 4 prio 19 pends -> request id=4; after ack, depth_o=2 and thr_o=19; two dones -> thr_o=256.
 - NestDepth=4 filled, IRQ 1 prio 0 pends -> irq_valid_o stays 0; one done -> request id=1.
 - Ack and done in the same cycle at depth 2 -> depth_o stays 2 and thr_o equals the claimed prio; edge on the claimed ID in the ack cycle -> pending stays 1.
 - Prio 255 at depth 0 -> serviced; assert rst_i while irq_valid_o=1 -> irq_valid_o=0 before the next edge.

Source files
------------

// File: rtl/edf_pkg.sv
// Shared defaults and FSM encoding for the EDF interrupt scheduler.
package edf_pkg;
  localparam int NR_IRQS    = 32;
  localparam int PRIO_WIDTH = 8;
  localparam int NEST_DEPTH = 4;

  typedef enum logic {
    IDLE,
    REQ
  } state_e;
endpackage

// File: rtl/irq_arbiter.sv
// Combinational earliest-deadline picker: lowest prio value wins, ties go to the lowest index.
module irq_arbiter #(
  parameter int NrIrqs    = 32,
  parameter int PrioWidth = 8,
  localparam int IdxW     = $clog2(NrIrqs)
) (
  input  logic [NrIrqs-1:0]                valid_i,
  input  logic [NrIrqs-1:0][PrioWidth-1:0] prio_i,
  output logic                             valid_o,
  output logic [IdxW-1:0]                  id_o,
  output logic [PrioWidth-1:0]             prio_o
);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    valid_o = 1'b0;
    id_o    = '0;
    prio_o  = '1;
    // Strict compare while scanning upwards keeps the lower index on a tie.
    for (int i = 0; i < NrIrqs; i++) begin
      if (valid_i[i] && (!valid_o || prio_i[i] < prio_o)) begin
        valid_o = 1'b1;
        id_o    = IdxW'(i);
        prio_o  = prio_i[i];
      end
    end
  end

endmodule

// File: rtl/edf_irq_sched.sv
// EDF interrupt scheduler: edge-latched pending bits, deadline arbitration and a nesting threshold stack.
module edf_irq_sched
  import edf_pkg::*;
#(
  parameter int NrIrqs    = NR_IRQS,
  parameter int PrioWidth = PRIO_WIDTH,
  parameter int NestDepth = NEST_DEPTH,
  localparam int IdxW     = $clog2(NrIrqs),
  localparam int ThrW     = PrioWidth + 1,
  localparam int DepthW   = $clog2(NestDepth + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NrIrqs-1:0]    irq_src_i,
  input  logic                 cfg_we_i,
  input  logic [IdxW-1:0]      cfg_idx_i,
  input  logic                 cfg_ie_i,
  input  logic [PrioWidth-1:0] cfg_prio_i,
  output logic                 irq_valid_o,
  output logic [IdxW-1:0]      irq_id_o,
  output logic [PrioWidth-1:0] irq_prio_o,
  input  logic                 irq_ack_i,
  input  logic                 irq_done_i,
  output logic [ThrW-1:0]      thr_o,
  output logic [DepthW-1:0]    depth_o
);

  localparam logic [ThrW-1:0] ThrReset = {1'b1, {PrioWidth{1'b0}}};

  state_e                         state_q, state_d;
  logic [NrIrqs-1:0]              src_q, pending_q, pending_d, ie_q;
  logic [NrIrqs-1:0][PrioWidth-1:0] prio_q;
  logic [ThrW-1:0]                thr_q, stack_top;
  logic [ThrW-1:0]                stack_q [NestDepth];
  logic [DepthW-1:0]              depth_q;
  logic                           arb_valid, take, claim, pop;
  logic [IdxW-1:0]                arb_id;
  logic [PrioWidth-1:0]           arb_prio;

  irq_arbiter #(
    .NrIrqs   (NrIrqs),
    .PrioWidth(PrioWidth)
  ) u_arbiter (
    .valid_i(pending_q & ie_q),
    .prio_i (prio_q),
    .valid_o(arb_valid),
    .id_o   (arb_id),
    .prio_o (arb_prio)
  );

  assign take  = arb_valid && ({1'b0, arb_prio} < thr_q) && (depth_q < DepthW'(NestDepth));
  assign claim = (state_q == REQ) && irq_ack_i;
  assign pop   = irq_done_i && (depth_q != '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (take) state_d = REQ;
      REQ:     if (irq_ack_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // An edge set is applied after the ack clear so a coincident edge survives the claim.
  always_comb begin
    pending_d = pending_q;
    if (claim) pending_d[irq_id_o] = 1'b0;
    pending_d = pending_d | (irq_src_i & ~src_q & ie_q);
    if (cfg_we_i && !cfg_ie_i) pending_d[cfg_idx_i] = 1'b0;
  end

  always_comb begin
    stack_top = '0;
    for (int k = 0; k < NestDepth; k++)
      if (depth_q == DepthW'(k + 1)) stack_top = stack_q[k];
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      src_q      <= '0;
      pending_q  <= '0;
      ie_q       <= '0;
      prio_q     <= '1;
      irq_id_o   <= '0;
      irq_prio_o <= '0;
    end else begin
      src_q     <= irq_src_i;
      pending_q <= pending_d;
      if (cfg_we_i) begin
        ie_q[cfg_idx_i]   <= cfg_ie_i;
        prio_q[cfg_idx_i] <= cfg_prio_i;
      end
      if (state_q == IDLE && take) begin
        irq_id_o   <= arb_id;
        irq_prio_o <= arb_prio;
      end
    end
  end

  // NOTE: the stack is a small register array, so it is reset explicitly rather than left unknown.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      thr_q   <= ThrReset;
      depth_q <= '0;
      for (int k = 0; k < NestDepth; k++) stack_q[k] <= '0;
    end else if (claim && pop) begin
      thr_q <= {1'b0, irq_prio_o};
    end else if (claim) begin
      for (int k = 0; k < NestDepth; k++)
        if (depth_q == DepthW'(k)) stack_q[k] <= thr_q;
      thr_q   <= {1'b0, irq_prio_o};
      depth_q <= depth_q + DepthW'(1);
    end else if (pop) begin
      thr_q   <= stack_top;
      depth_q <= depth_q - DepthW'(1);
    end
  end

  assign irq_valid_o = (state_q == REQ);
  assign thr_o       = thr_q;
  assign depth_o     = depth_q;

endmodule

// File: tb/tb_edf_irq_sched.sv
// Directed bench for edf_irq_sched with an offer scoreboard and threshold/depth checks.
module tb_edf_irq_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] irq_src;
  logic        cfg_we;
  logic [4:0]  cfg_idx;
  logic        cfg_ie;
  logic [7:0]  cfg_prio;
  logic        irq_valid;
  logic [4:0]  irq_id;
  logic [7:0]  irq_prio;
  logic        irq_ack;
  logic        irq_done;
  logic [8:0]  thr;
  logic [2:0]  depth;

  typedef struct packed {
    logic [4:0] id;
    logic [7:0] prio;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  edf_irq_sched dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .irq_src_i  (irq_src),
    .cfg_we_i   (cfg_we),
    .cfg_idx_i  (cfg_idx),
    .cfg_ie_i   (cfg_ie),
    .cfg_prio_i (cfg_prio),
    .irq_valid_o(irq_valid),
    .irq_id_o   (irq_id),
    .irq_prio_o (irq_prio),
    .irq_ack_i  (irq_ack),
    .irq_done_i (irq_done),
    .thr_o      (thr),
    .depth_o    (depth)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int idx, input logic ie, input int prio);
    cfg_we = 1'b1; cfg_idx = 5'(idx); cfg_ie = ie; cfg_prio = 8'(prio);
    cycle();
    cfg_we = 1'b0;
  endtask

  task automatic pulse(input int idx);
    irq_src = 32'd1 << idx;
    cycle();
    irq_src = '0;
  endtask

  task automatic ack();
    irq_ack = 1'b1;
    cycle();
    irq_ack = 1'b0;
  endtask

  task automatic done();
    irq_done = 1'b1;
    cycle();
    irq_done = 1'b0;
  endtask

  task automatic expect_offer(input int id, input int prio);
    exp_t e;
    e.id = 5'(id); e.prio = 8'(prio);
    sb.push_back(e);
  endtask

  // Bounded wait for an offer, then compare it against the oldest scoreboard entry.
  task automatic await_offer(input string tag);
    exp_t e;
    int   n = 0;
    while (irq_valid !== 1'b1 && n < 20) begin
      cycle();
      n++;
    end
    chk({tag, "_valid"}, irq_valid, 1);
    chk({tag, "_sb_nonempty"}, sb.size() != 0, 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_id"}, irq_id, e.id);
      chk({tag, "_prio"}, irq_prio, e.prio);
    end
  endtask

  initial begin
    rst = 1'b1; irq_src = '0; cfg_we = 1'b0; cfg_idx = '0; cfg_ie = 1'b0;
    cfg_prio = '0; irq_ack = 1'b0; irq_done = 1'b0;
    cycle(); cycle();
    chk("rst_valid", irq_valid, 0);
    chk("rst_id", irq_id, 0);
    chk("rst_prio", irq_prio, 0);
    chk("rst_thr", thr, 256);
    chk("rst_depth", depth, 0);
    rst = 1'b0;
    cycle();

    // Single request: one-cycle latency from pending to offer, then claim.
    cfg(5, 1'b1, 20);
    pulse(5);
    expect_offer(5, 20);
    chk("s1_not_yet", irq_valid, 0);
    cycle();
    await_offer("s1");
    ack();
    chk("s1_thr", thr, 20);
    chk("s1_depth", depth, 1);
    chk("s1_valid_after_ack", irq_valid, 0);
    done();
    chk("s1_thr_done", thr, 256);
    chk("s1_depth_done", depth, 0);

    // Ack in IDLE and done at depth 0 are both ignored.
    ack();
    done();
    chk("idle_ack_depth", depth, 0);
    chk("idle_ack_thr", thr, 256);

    // Equal deadlines: lower index first.
    cfg(3, 1'b1, 7);
    cfg(9, 1'b1, 7);
    irq_src = (32'd1 << 3) | (32'd1 << 9);
    cycle();
    irq_src = '0;
    expect_offer(3, 7);
    await_offer("s2_first");
    ack();
    cycle(); cycle();
    chk("s2_no_equal_preempt", irq_valid, 0);
    done();
    expect_offer(9, 7);
    await_offer("s2_second");
    ack();
    done();

    // Preemption needs a strictly earlier deadline.
    pulse(5);
    expect_offer(5, 20);
    await_offer("s3_outer");
    ack();
    cfg(2, 1'b1, 20);
    pulse(2);
    cycle(); cycle();
    chk("s3_equal_blocked", irq_valid, 0);
    cfg(4, 1'b1, 19);
    pulse(4);
    expect_offer(4, 19);
    await_offer("s3_inner");
    ack();
    chk("s3_depth2", depth, 2);
    chk("s3_thr19", thr, 19);
    done();
    chk("s3_thr20", thr, 20);
    done();
    chk("s3_thr256", thr, 256);
    chk("s3_depth0", depth, 0);
    expect_offer(2, 20);
    await_offer("s3_deferred");
    ack();
    done();

    // Fill the nesting stack, then a most-urgent source must wait for a slot.
    cfg(10, 1'b1, 50);
    cfg(11, 1'b1, 40);
    cfg(12, 1'b1, 30);
    cfg(13, 1'b1, 25);
    pulse(10); expect_offer(10, 50); await_offer("s4_l1"); ack();
    pulse(11); expect_offer(11, 40); await_offer("s4_l2"); ack();
    pulse(12); expect_offer(12, 30); await_offer("s4_l3"); ack();
    pulse(13); expect_offer(13, 25); await_offer("s4_l4"); ack();
    chk("s4_full_depth", depth, 4);
    chk("s4_full_thr", thr, 25);
    cfg(1, 1'b1, 0);
    pulse(1);
    cycle(); cycle(); cycle();
    chk("s4_blocked_full", irq_valid, 0);
    done();
    chk("s4_thr_after_pop", thr, 30);
    expect_offer(1, 0);
    await_offer("s4_after_slot");
    ack();
    chk("s4_thr0", thr, 0);
    done(); done(); done();
    chk("s4_thr_unwind", thr, 50);
    done();
    chk("s4_thr_empty", thr, 256);
    chk("s4_depth_empty", depth, 0);

    // Ack and done together at depth 2, with a new edge on the claimed source.
    pulse(10); expect_offer(10, 50); await_offer("s5_l1"); ack();
    pulse(11); expect_offer(11, 40); await_offer("s5_l2"); ack();
    pulse(13); expect_offer(13, 25); await_offer("s5_offer");
    irq_ack = 1'b1; irq_done = 1'b1; irq_src = 32'd1 << 13;
    cycle();
    irq_ack = 1'b0; irq_done = 1'b0; irq_src = '0;
    chk("s5_depth_kept", depth, 2);
    chk("s5_thr_claimed", thr, 25);
    cycle();
    chk("s5_no_offer", irq_valid, 0);
    done();
    chk("s5_below_kept", thr, 50);
    expect_offer(13, 25);
    await_offer("s5_repend");
    ack();
    done(); done();
    chk("s5_thr_empty", thr, 256);

    // All-ones deadline is serviceable at depth 0; reset drops the request at once.
    cfg(7, 1'b1, 255);
    pulse(7);
    expect_offer(7, 255);
    await_offer("s6_255");
    ack();
    chk("s6_thr255", thr, 255);
    done();
    pulse(7);
    expect_offer(7, 255);
    await_offer("s6_pre_rst");
    rst = 1'b1;
    #1;
    chk("s6_rst_async_valid", irq_valid, 0);
    chk("s6_rst_async_thr", thr, 256);
    cycle();
    rst = 1'b0;
    chk("s6_rst_depth", depth, 0);
    pulse(7);
    cycle(); cycle();
    chk("s6_disabled_after_rst", irq_valid, 0);

    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
